// File: rtl/battleship_pkg.sv
// Shared types and default board constants for the battleship shot evaluator.
package battleship_pkg;

   localparam int DEF_BOARD_W = 10;
   localparam int DEF_BOARD_H = 10;
   localparam int DEF_COORD_W = 4;
   localparam int DEF_RADIUS  = 1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } eval_state_t;

   typedef struct packed {
      logic hit;
      logic near;
      logic miss;
      logic wrong;
   } shot_result_t;

endpackage

// File: rtl/window_scanner.sv
// Walks the bomb window around a latched centre, one cell per step,
// row-major (dy outer, dx inner), reporting the board cell and whether it is on the board.
module window_scanner
   import battleship_pkg::*;
#(
   parameter int BOARD_W = DEF_BOARD_W,
   parameter int BOARD_H = DEF_BOARD_H,
   parameter int COORD_W = DEF_COORD_W,
   parameter int RADIUS  = DEF_RADIUS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [COORD_W-1:0] centre_x,
   input  logic [COORD_W-1:0] centre_y,
   input  logic               big,
   output logic [COORD_W-1:0] cell_x,
   output logic [COORD_W-1:0] cell_y,
   output logic               in_bounds,
   output logic               last
);

   localparam logic signed [COORD_W:0] R_S     = (COORD_W+1)'(RADIUS);
   localparam logic signed [COORD_W:0] ONE_S   = (COORD_W+1)'(1);
   localparam logic signed [COORD_W:0] MAX_X_S = (COORD_W+1)'(BOARD_W);
   localparam logic signed [COORD_W:0] MAX_Y_S = (COORD_W+1)'(BOARD_H);

   logic [COORD_W-1:0]        cx, cy;
   logic                      big_q;
   logic signed [COORD_W:0]   dx, dy;
   logic signed [COORD_W:0]   hi, lo;
   logic signed [COORD_W:0]   sx, sy;

   // Offset range for the latched window size; a small shot only visits (0,0).
   always_comb begin
      hi = big_q ? R_S : '0;
      lo = -hi;
   end

   // Latch centre/size on start, then advance the offset counters each step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cx    <= '0;
         cy    <= '0;
         big_q <= 1'b0;
         dx    <= '0;
         dy    <= '0;
      end else if (start) begin
         cx    <= centre_x;
         cy    <= centre_y;
         big_q <= big;
         dx    <= big ? -R_S : '0;
         dy    <= big ? -R_S : '0;
      end else if (step) begin
         if (dx == hi) begin
            dx <= lo;
            dy <= dy + ONE_S;
         end else begin
            dx <= dx + ONE_S;
         end
      end
   end

   // Signed cell position; anything off the board is flagged, never wrapped.
   always_comb begin
      sx        = $signed({1'b0, cx}) + dx;
      sy        = $signed({1'b0, cy}) + dy;
      in_bounds = (sx >= ONE_S) && (sx <= MAX_X_S) && (sy >= ONE_S) && (sy <= MAX_Y_S);
      cell_x    = sx[COORD_W-1:0];
      cell_y    = sy[COORD_W-1:0];
      last      = (dx == hi) && (dy == hi);
   end

endmodule

// File: rtl/shot_evaluator.sv
// Board state holder and shot evaluator: loadable ship/near/hit bitmaps,
// one shot at a time, window scan one cell per cycle, one-cycle result strobe.
module shot_evaluator
   import battleship_pkg::*;
#(
   parameter int BOARD_W = DEF_BOARD_W,
   parameter int BOARD_H = DEF_BOARD_H,
   parameter int COORD_W = DEF_COORD_W,
   parameter int RADIUS  = DEF_RADIUS,
   localparam int CELLS  = BOARD_W * BOARD_H,
   localparam int CNT_W  = $clog2(CELLS + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               load_en,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   input  logic               load_ship,
   input  logic               load_near,
   input  logic               shot_valid,
   output logic               shot_ready,
   input  logic [COORD_W-1:0] shot_x,
   input  logic [COORD_W-1:0] shot_y,
   input  logic               shot_big,
   output logic               res_valid,
   output logic               res_hit,
   output logic               res_near,
   output logic               res_miss,
   output logic               res_wrong,
   output logic [CNT_W-1:0]   res_hit_count,
   output logic [CNT_W-1:0]   ships_left,
   output logic               all_sunk
);

   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(BOARD_W);
   localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(BOARD_H);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   eval_state_t        state;
   logic [CELLS-1:0]   ship_map, near_map, hit_map;
   logic [CNT_W-1:0]   hit_count;
   logic               near_seen;
   shot_result_t       res;

   logic [COORD_W-1:0] scan_x, scan_y;
   logic               scan_in_bounds, scan_last;
   logic               scan_start, scan_step;

   logic               load_in_range, shot_in_range, shot_wrong;
   logic [IDX_W-1:0]   load_idx, shot_idx, scan_idx;
   logic               cell_new_hit, cell_near;
   logic [CNT_W-1:0]   total_hits;
   logic               total_near;

   function automatic logic [IDX_W-1:0] cell_index(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return IDX_W'((int'(y) - 1) * BOARD_W + int'(x) - 1);
   endfunction

   // Decode addressed cells and the outcome of the cell currently being scanned.
   always_comb begin
      load_in_range = (load_x != '0) && (load_x <= MAX_X) && (load_y != '0) && (load_y <= MAX_Y);
      shot_in_range = (shot_x != '0) && (shot_x <= MAX_X) && (shot_y != '0) && (shot_y <= MAX_Y);
      load_idx      = cell_index(load_x, load_y);
      shot_idx      = cell_index(shot_x, shot_y);
      scan_idx      = cell_index(scan_x, scan_y);
      shot_wrong    = !shot_in_range || hit_map[shot_idx];
      cell_new_hit  = scan_in_bounds && ship_map[scan_idx] && !hit_map[scan_idx];
      cell_near     = scan_in_bounds && near_map[scan_idx];
      total_hits    = hit_count + (cell_new_hit ? CNT_ONE : '0);
      total_near    = near_seen || cell_near;
      shot_ready    = (state == IDLE) && !clear && !load_en;
      scan_start    = shot_ready && shot_valid && !shot_wrong;
      scan_step     = (state == SCAN);
   end

   window_scanner #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .COORD_W (COORD_W),
      .RADIUS  (RADIUS)
   ) u_scanner (
      .clock     (clock),
      .reset     (reset),
      .start     (scan_start),
      .step      (scan_step),
      .centre_x  (shot_x),
      .centre_y  (shot_y),
      .big       (shot_big),
      .cell_x    (scan_x),
      .cell_y    (scan_y),
      .in_bounds (scan_in_bounds),
      .last      (scan_last)
   );

   // Control FSM plus bitmap, counter and registered result updates.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         ship_map      <= '0;
         near_map      <= '0;
         hit_map       <= '0;
         ships_left    <= '0;
         hit_count     <= '0;
         near_seen     <= 1'b0;
         res           <= '0;
         res_valid     <= 1'b0;
         res_hit_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  ship_map   <= '0;
                  near_map   <= '0;
                  hit_map    <= '0;
                  ships_left <= '0;
               end else if (load_en) begin
                  if (load_in_range) begin
                     ship_map[load_idx] <= load_ship;
                     near_map[load_idx] <= load_near;
                     hit_map[load_idx]  <= 1'b0;
                     if (!ship_map[load_idx] && load_ship)
                        ships_left <= ships_left + CNT_ONE;
                     else if (ship_map[load_idx] && !load_ship && !hit_map[load_idx])
                        ships_left <= ships_left - CNT_ONE;
                  end
               end else if (shot_valid) begin
                  if (shot_wrong) begin
                     state         <= DONE;
                     res_valid     <= 1'b1;
                     res           <= '{hit: 1'b0, near: 1'b0, miss: 1'b0, wrong: 1'b1};
                     res_hit_count <= '0;
                  end else begin
                     state     <= SCAN;
                     hit_count <= '0;
                     near_seen <= 1'b0;
                  end
               end
            end
            SCAN: begin
               if (cell_new_hit) begin
                  hit_map[scan_idx] <= 1'b1;
                  ships_left        <= ships_left - CNT_ONE;
               end
               hit_count <= total_hits;
               near_seen <= total_near;
               if (scan_last) begin
                  state         <= DONE;
                  res_valid     <= 1'b1;
                  res_hit_count <= total_hits;
                  res.hit       <= (total_hits != '0);
                  res.near      <= (total_hits == '0) && total_near;
                  res.miss      <= (total_hits == '0) && !total_near;
                  res.wrong     <= 1'b0;
               end
            end
            DONE: begin
               state         <= IDLE;
               res_valid     <= 1'b0;
               res           <= '0;
               res_hit_count <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result flags straight from the registered result; sunk flag from the live count.
   always_comb begin
      res_hit   = res.hit;
      res_near  = res.near;
      res_miss  = res.miss;
      res_wrong = res.wrong;
      all_sunk  = (ships_left == '0);
   end

endmodule

// File: doc/shot_evaluator.md
Name: shot_evaluator

Overview:
- Sequential, parametrised successor to the combinational near-miss decoder.
- Holds loadable ship, near-miss and already-hit bitmaps for a BOARD_W x BOARD_H board. It accepts one shot at a time over a valid/ready handshake and scans a square bomb window one cell per cycle.
- Returns a one-cycle result (hit / near-miss / miss / wrong) and keeps a remaining-ship-cell count.
- Sits between the player-input FSM and the score/display logic.

Parameters:
- BOARD_W, 10, board columns; legal x is 1..BOARD_W (1-based).
- BOARD_H, 10, board rows; legal y is 1..BOARD_H.
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W > max(BOARD_W, BOARD_H).
- RADIUS, 1, big-bomb half-width; the window is (2*RADIUS+1)^2 cells.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  clears all three bitmaps and ships_left; honoured in IDLE only.
- load_en  in  1  writes one board cell; honoured in IDLE only.
- load_x, load_y  in  COORD_W  cell to write; writes to out-of-range cells are ignored.
- load_ship  in  1  ship bit to write.
- load_near  in  1  near-miss bit to write.
- shot_valid  in  1  shot request.
- shot_ready  out  1  high in IDLE when clear=0 and load_en=0.
- shot_x, shot_y  in  COORD_W  shot centre.
- shot_big  in  1  1 = window scan, 0 = centre cell only.
- res_valid  out  1  one-cycle result strobe.
- res_hit, res_near, res_miss, res_wrong  out  1 each  result class; exactly one is high while res_valid=1.
- res_hit_count  out  $clog2(W*H+1)  cells newly hit by this shot.
- ships_left  out  $clog2(W*H+1)  ship cells not yet hit.
- all_sunk  out  1  ships_left==0.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all bitmaps=0; ships_left=0.
  - res_* = 0; res_hit_count = 0; all_sunk = 1; shot_ready = 1.
- States: IDLE, SCAN, DONE.
- IDLE priority is clear > load_en > shot.
- Load:
  - Writes the ship and near bits and clears the hit bit at (load_x, load_y).
  - ships_left +1 if the ship bit goes 0→1.
  - ships_left -1 if the ship bit goes 1→0 on an unhit cell.
  - Effect is visible the next cycle.
- Shot accept: shot_valid && shot_ready at edge T. The bench holds inputs at T, and the block latches centre and size.
- Wrong shot: the centre is out of range, or the centre is already hit. Then go directly to DONE; res_valid=1, res_wrong=1 at T+1; no bitmap change.
- SCAN:
  - N = 1 (small) or (2R+1)^2 (big) cycles, occupying T+1..T+N.
  - Visit order: row-major, dy=-R..R outer, dx=-R..R inner; small visits offset (0,0) only.
  - Offsets are computed in COORD_W+1-bit signed arithmetic. Cells with x<1, x>BOARD_W, y<1 or y>BOARD_H are skipped (counted in N, no effect). There is no wrap-around.
  - Visited cell with ship=1 and hit=0:
    - set its hit bit;
    - increment hit_count;
    - ships_left -1 in that same cycle.
  - Visited cell with near=1 (whether or not it was hit) sets near_seen.
  - An already-hit ship cell contributes nothing.
- DONE (single cycle, T+N+1):
  - res_valid=1.
  - Classification: res_hit if hit_count>0; else res_near if near_seen; else res_miss.
  - res_hit_count = hit_count.
  - Next state is IDLE.
  - shot_ready is low from T+1 through DONE.
- res_* outputs are 0 whenever res_valid=0.
- Inputs during SCAN/DONE (load_en, clear, shot_valid) are ignored, not queued.
- all_sunk is combinational from ships_left.
- Reset mid-SCAN aborts the shot. Partial hit marks are discarded because reset clears all bitmaps.

Decomposition:
- battleship_pkg:
  - typedef enum {IDLE, SCAN, DONE} eval_state_t;
  - typedef struct {hit, near, miss, wrong} shot_result_t;
  - default board constants.
- Sub-module window_scanner:
  - Inputs: centre, big, start.
  - Counts the dx/dy offsets.
  - Outputs cell x/y, in_bounds and last.

Test Plan:
1. Load ship at (3,4) and near at (3,5); small shot (3,4) → res_valid at T+2, res_hit=1, res_hit_count=1, ships_left 1→0, all_sunk=1.
2. Small shot (3,5) on the same board with ship unhit → res_near=1 at T+2. Small shot (6,6) → res_miss=1.
3. Ships at (1,1), (2,1), (2,2); big shot (1,1) with RADIUS=1:
   - 9 scan cycles, 5 of them out-of-bounds;
   - res_valid at T+10, res_hit=1, res_hit_count=3, ships_left=0.
4. Repeat small shot (3,4) after test 1 → res_wrong=1 at T+1. Shot (0,4) and shot (11,4) → res_wrong=1; bitmaps unchanged.
5. Handshake and reset:
   - Hold shot_valid during SCAN → shot_ready=0 and no second accept.
   - load_en during SCAN → ignored.
   - Assert reset mid-SCAN → immediate IDLE, ships_left=0, res_valid=0.
6. clear in IDLE with ships loaded → ships_left=0 the next cycle. A shot at a former ship cell → res_miss.
